// File: rtl/mesh_pipe_pkg.sv
// Shared helpers for mesh pipe endpoints: address sizing and the minimum
// receive buffer depth needed to cover the credit round trip.
package mesh_pipe_pkg;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A word leaves the sender, crosses the forward pipe, is registered here,
  // popped, turned into a registered credit and carried back by the reverse
  // pipe. Every cycle of that loop needs one buffer entry for full rate.
  function automatic int min_rx_depth(input int fwd_depth, input int rev_depth);
    return fwd_depth + rev_depth + 2;
  endfunction

endpackage

// File: rtl/mesh_rx_ram.sv
// Simple dual-port storage for the receive FIFO: one synchronous write port,
// one asynchronous read port, no reset on the array.
module mesh_rx_ram
  import mesh_pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the accepted word at the write pointer.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read keeps the head visible in the same cycle the pointer moves.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mesh_pipe_credit_rx.sv
// Receiving endpoint of a mesh pipe link. Absorbs every arriving word into a
// FIFO, presents the head to the consumer and returns one credit per pop.
//
// Handshake: out_valid/out_ready follow strict valid/ready rules. out_valid
// depends only on registered occupancy, never on out_ready; a transfer happens
// on any rising clock edge where both are high. in_valid has no ready: a word
// that arrives when the FIFO is full and nothing pops is lost and flagged.
module mesh_pipe_credit_rx
  import mesh_pipe_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 4,
  parameter int FWD_PIPE_DEPTH = 1,
  parameter int REV_PIPE_DEPTH = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          credit_out,
  output logic [clog2(DEPTH):0]         count,
  output logic                          overflow
);

  localparam int ADDR_WIDTH = clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] last_ptr   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   full_count = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   one_count  = (ADDR_WIDTH + 1)'(1);

  // A buffer too shallow for the credit loop cannot sustain full rate; refuse to build.
  if (WIDTH < 1 || DEPTH < 2 ||
      DEPTH < min_rx_depth(FWD_PIPE_DEPTH, REV_PIPE_DEPTH)) begin : g_bad_params
    $error("mesh_pipe_credit_rx: DEPTH %0d too small for pipe depths %0d+%0d",
           DEPTH, FWD_PIPE_DEPTH, REV_PIPE_DEPTH);
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Transfer decisions: a full FIFO still accepts a word if the head leaves this cycle.
  always_comb begin
    pop  = out_valid && out_ready;
    push = in_valid && ((count < full_count) || pop);
    drop = in_valid && !push;
  end

  assign out_valid = (count != '0);

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + one_count;
        2'b01:   count <= count - one_count;
        default: count <= count;
      endcase
    end
  end

  // One credit per consumed word, one cycle later; dropped words never earn one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credit_out <= 1'b0;
    end else begin
      credit_out <= pop;
    end
  end

  // Sticky flag: a drop means the sender broke the credit contract.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  mesh_rx_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_mesh_pipe_credit_rx.sv
// Directed bench for mesh_pipe_credit_rx with WIDTH=8, DEPTH=4.
module tb_mesh_pipe_credit_rx;

  localparam int W = 8;
  localparam int D = 4;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         credit_out;
  logic [2:0]   count;
  logic         overflow;

  int n_checks;
  int n_pass;
  int credit_cnt;

  logic [W-1:0] exp_q[$];

  mesh_pipe_credit_rx #(
    .WIDTH          (W),
    .DEPTH          (D),
    .FWD_PIPE_DEPTH (1),
    .REV_PIPE_DEPTH (1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .credit_out (credit_out),
    .count      (count),
    .overflow   (overflow)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: advance one clock, land 1 time unit after the edge, tally credits.
  task automatic step();
    @(posedge clock);
    #1;
    if (credit_out === 1'b1) credit_cnt = credit_cnt + 1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int occ;
    int sent;
    int popped;
    int cyc;
    logic pop_m;
    logic [W-1:0] e;

    n_checks   = 0;
    n_pass     = 0;
    credit_cnt = 0;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;

    // Reset state
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_credit", 32'(credit_out), 0);
    check("rst_overflow", 32'(overflow), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();

    // Single word with consumer ready
    out_ready = 1'b1;
    check("single_count0", 32'(count), 0);
    check("single_no_bypass", 32'(out_valid), 0);
    push_word(8'hA5);
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 32'h A5);
    check("single_count1", 32'(count), 1);
    check("single_no_credit_yet", 32'(credit_out), 0);
    step();
    check("single_credit", 32'(credit_out), 1);
    check("single_count2", 32'(count), 0);
    check("single_empty", 32'(out_valid), 0);
    step();
    check("single_credit_end", 32'(credit_out), 0);

    // Fill and drain
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_word(W'(i));
      exp_q.push_back(W'(i));
    end
    check("fill_count", 32'(count), 4);
    check("fill_head", 32'(out_data), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      check("drain_data", 32'(out_data), 32'(e));
      step();
      check("drain_credit", 32'(credit_out), 1);
    end
    out_ready = 1'b0;
    check("drain_count", 32'(count), 0);
    step();
    check("drain_credit_end", 32'(credit_out), 0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) push_word(W'(i));
    check("full_count", 32'(count), 4);
    check("full_head", 32'(out_data), 1);
    in_valid  = 1'b1;
    in_data   = 8'h05;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pushpop_count", 32'(count), 4);
    check("pushpop_overflow", 32'(overflow), 0);
    check("pushpop_head", 32'(out_data), 2);
    check("pushpop_credit", 32'(credit_out), 1);
    step();

    // Overflow: full, no pop, extra word is dropped
    push_word(8'hEE);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 4);
    step();
    check("ovf_sticky", 32'(overflow), 1);
    credit_cnt = 0;
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      check("ovf_drain_data", 32'(out_data), 32'(e));
      step();
    end
    out_ready = 1'b0;
    step();
    step();
    check("ovf_credits", 32'(credit_cnt), 4);
    check("ovf_empty", 32'(out_valid), 0);
    check("ovf_still_set", 32'(overflow), 1);

    // Wrap-around stream with out_ready toggling; model gates the sender on credits
    credit_cnt = 0;
    occ    = 0;
    sent   = 0;
    popped = 0;
    cyc    = 0;
    exp_q.delete();
    while ((sent < 10 || occ > 0) && cyc < 80) begin
      out_ready = (cyc % 2 == 0);
      pop_m = (occ > 0) && out_ready;
      if (pop_m) begin
        e = exp_q.pop_front();
        check("wrap_data", 32'(out_data), 32'(e));
        popped = popped + 1;
      end
      if (sent < 10 && (occ < D || pop_m)) begin
        in_valid = 1'b1;
        in_data  = W'(8'h10 + sent);
        exp_q.push_back(W'(8'h10 + sent));
        sent = sent + 1;
        occ  = occ + 1;
      end else begin
        in_valid = 1'b0;
      end
      if (pop_m) occ = occ - 1;
      step();
      cyc = cyc + 1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("wrap_bounded", 32'(cyc < 80), 1);
    check("wrap_popped", 32'(popped), 10);
    step();
    check("wrap_credits", 32'(credit_cnt), 10);
    check("wrap_empty", 32'(count), 0);

    // Asynchronous reset mid-stream with a credit pulse in flight
    for (int i = 0; i < 4; i++) push_word(W'(8'h20 + i));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pre_rst_count", 32'(count), 3);
    check("pre_rst_credit", 32'(credit_out), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_credit", 32'(credit_out), 0);
    check("async_rst_overflow", 32'(overflow), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();
    push_word(8'h3C);
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_data", 32'(out_data), 32'h3C);
    check("post_rst_count", 32'(count), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
